// File: rtl/dcnn_pkg.sv
// Shared constants and state encoding for the CNN input row path.
// Imported by the row sequencer and its serializer.
package dcnn_pkg;

  localparam int ROW_W_DEF  = 480;
  localparam int WORD_W_DEF = 16;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT_ROW = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_FIN      = 3'd4;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    REQ      = S_REQ,
    WAIT_ROW = S_WAIT_ROW,
    SHIFT    = S_SHIFT,
    FIN      = S_FIN
  } state_e;

  function automatic int words_of(
    input int row_w,
    input int word_w
  );
    return row_w / word_w;
  endfunction

endpackage

// File: rtl/row_serializer.sv
// Holds one row and hands it out LSW first, one word per accept.
// valid drops after the last word until the next load.
module row_serializer
  import dcnn_pkg::*;
#(
  parameter int ROW_W  = ROW_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              accept_i,
  input  logic              clear_i,
  input  logic [ROW_W-1:0]  row_i,
  output logic [WORD_W-1:0] word_o,
  output logic              valid_o,
  output logic              last_o
);

  localparam int WORDS = words_of(ROW_W, WORD_W);
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [ROW_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;

  assign word_o  = shreg_q[WORD_W-1:0];
  assign valid_o = vld_q;
  assign last_o  = (cnt_q == CW'(WORDS - 1));

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    if (clear_i) begin
      shreg_d = '0;
      cnt_d   = '0;
      vld_d   = 1'b0;
    end else if (load_i) begin
      shreg_d = row_i;
      cnt_d   = '0;
      vld_d   = 1'b1;
    end else if (accept_i && vld_q) begin
      shreg_d = shreg_q >> WORD_W;
      cnt_d   = last_o ? '0 : cnt_q + 1'b1;
      vld_d   = !last_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: rtl/row_send_ctrl.sv
// Row request / serialise sequencer feeding the CNN input datapath.
// Counts rows per image, raises stop at image end or abort.
module row_send_ctrl
  import dcnn_pkg::*;
#(
  parameter int ROW_W    = ROW_W_DEF,
  parameter int WORD_W   = WORD_W_DEF,
  parameter int IMG_ROWS = 30,
  localparam int RW      = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              interrupt,
  output logic              row_req,
  input  logic [ROW_W-1:0]  row_in,
  input  logic              row_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [RW-1:0]     row_idx,
  output logic              busy,
  output logic              stop,
  output logic              done
);

  state_e        state_q, state_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          load, clear, accept, last;

  row_serializer #(
    .ROW_W  (ROW_W),
    .WORD_W (WORD_W)
  ) u_ser (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (load),
    .accept_i (accept),
    .clear_i  (clear),
    .row_i    (row_in),
    .word_o   (word_out),
    .valid_o  (word_valid),
    .last_o   (last)
  );

  // an abort beats a same-cycle accept
  assign accept = word_valid && word_ready && !interrupt;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    load      = 1'b0;
    clear     = 1'b0;
    if (state_q != IDLE && interrupt) begin
      state_d   = IDLE;
      row_cnt_d = '0;
      clear     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !interrupt) begin
            row_cnt_d = '0;
            state_d   = REQ;
          end
        end
        REQ: state_d = WAIT_ROW;
        WAIT_ROW: begin
          if (row_valid) begin
            load    = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (accept && last) begin
            if (row_cnt_q == RW'(IMG_ROWS - 1)) begin
              state_d = FIN;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
              state_d   = REQ;
            end
          end
        end
        FIN: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  assign row_req = (state_q == REQ);
  assign busy    = (state_q != IDLE);
  assign stop    = (state_q == IDLE) || (state_q == FIN);
  assign done    = (state_q == FIN);
  assign row_idx = row_cnt_q;

endmodule

// File: tb/tb_row_send_ctrl.sv
// Randomised bench for row_send_ctrl: per-image word stream model,
// backpressure, multi-row, abort, ignored events and reset.
module tb_row_send_ctrl;

  localparam int ROW_W  = 480;
  localparam int WORD_W = 16;
  localparam int ROWS   = 3;
  localparam int WORDS  = ROW_W / WORD_W;

  logic              clk = 0;
  logic              rst = 0;
  logic              start = 0;
  logic              interrupt = 0;
  logic              row_req;
  logic [ROW_W-1:0]  row_in = '0;
  logic              row_valid = 0;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready = 0;
  logic [1:0]        row_idx;
  logic              busy;
  logic              stop;
  logic              done;

  int checks = 0;
  int errors = 0;

  row_send_ctrl #(
    .ROW_W    (ROW_W),
    .WORD_W   (WORD_W),
    .IMG_ROWS (ROWS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .interrupt  (interrupt),
    .row_req    (row_req),
    .row_in     (row_in),
    .row_valid  (row_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .row_idx    (row_idx),
    .busy       (busy),
    .stop       (stop),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst = 0;
    start = 0;
    @(negedge clk);
    checks++;
    if (stop !== 1 || busy !== 0 || row_req !== 0 ||
        word_valid !== 0 || done !== 0 ||
        word_out !== 0 || row_idx !== 0) begin
      errors++;
      $display("FAIL reset: stop=%b busy=%b req=%b wv=%b done=%b wo=%h idx=%0d want 1 0 0 0 0 0 0",
               stop, busy, row_req, word_valid, done, word_out, row_idx);
    end
    rst = 1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (stop !== 1 || busy !== 0 || row_req !== 0 ||
          word_valid !== 0 || done !== 0) begin
        errors++;
        $display("FAIL idle: stop=%b busy=%b req=%b wv=%b done=%b want 1 0 0 0 0",
                 stop, busy, row_req, word_valid, done);
      end
    end
  endtask

  // Runs one image. bp: 0 ready high, 1 pattern 1001, 2 random.
  // ab_row < 0 means no abort. inc: LSW-first words 1..30.
  task automatic xfer(
    input string nm,
    input int    dly,
    input int    bp,
    input int    ab_row,
    input int    ab_word,
    input bit    poke,
    input bit    inc
  );
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] prev_w;
    bit prev_hold, prev_req, fin, ab, pk;
    int acc, reqs, cnt, last_acc, give, cyc;
    prev_w = '0;
    prev_hold = 0;
    prev_req = 0;
    fin = 0;
    ab = 0;
    pk = poke;
    acc = 0;
    reqs = 0;
    cnt = 0;
    last_acc = -10;
    give = -10;
    cyc = 0;
    @(negedge clk);
    start = 1;
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 0;
      row_valid = 0;
      if (ab) begin
        interrupt = 0;
        checks++;
        if (busy !== 0 || word_valid !== 0 || stop !== 1 ||
            done !== 0 || row_idx !== 0) begin
          errors++;
          $display("FAIL %s abort: busy=%b wv=%b stop=%b done=%b idx=%0d want 0 0 1 0 0",
                   nm, busy, word_valid, stop, done, row_idx);
        end
        repeat (6) begin
          @(negedge clk);
          checks++;
          if (done !== 0 || busy !== 0 || row_req !== 0) begin
            errors++;
            $display("FAIL %s post-abort: done=%b busy=%b req=%b want 0 0 0",
                     nm, done, busy, row_req);
          end
        end
        fin = 1;
      end else begin
        if (row_req) begin
          checks++;
          if (prev_req) begin
            errors++;
            $display("FAIL %s req_pulse: row_req high 2 cycles, want 1", nm);
          end
          reqs++;
        end
        prev_req = row_req;
        if (cyc == give + 1) begin
          checks++;
          if (word_valid !== 1) begin
            errors++;
            $display("FAIL %s first_word: word_valid=%b want 1", nm, word_valid);
          end
        end
        if (prev_hold) begin
          checks++;
          if (word_valid !== 1 || word_out !== prev_w) begin
            errors++;
            $display("FAIL %s hold: wv=%b word=%h want 1 %h",
                     nm, word_valid, word_out, prev_w);
          end
        end
        if (done) begin
          checks++;
          if (acc != ROWS * WORDS || last_acc != cyc - 1 || stop !== 1) begin
            errors++;
            $display("FAIL %s done: words=%0d last_acc=%0d cyc=%0d stop=%b want %0d %0d 1",
                     nm, acc, last_acc, cyc, stop, ROWS * WORDS, cyc - 1);
          end
          checks++;
          if (reqs != ROWS) begin
            errors++;
            $display("FAIL %s reqs: got %0d want %0d", nm, reqs, ROWS);
          end
          fin = 1;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            for (int i = 0; i < WORDS; i++) begin
              w = inc ? WORD_W'(i + 1) : WORD_W'($urandom);
              row_in[i*WORD_W +: WORD_W] = w;
              exp_q.push_back(w);
            end
            row_valid = 1;
            give = cyc;
          end
        end
        if (row_req) cnt = dly;
        case (bp)
          0: word_ready = 1;
          1: word_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: word_ready = 1'($urandom_range(0, 1));
        endcase
        if (pk && acc == 5 && word_valid) begin
          start = 1;
          row_valid = 1;
          row_in = {15{32'hDEADBEEF}};
          pk = 0;
        end
        if (word_valid && ab_row >= 0 &&
            acc == ab_row * WORDS + ab_word) begin
          interrupt = 1;
          word_ready = 1;
          ab = 1;
        end else if (word_valid && word_ready) begin
          checks++;
          w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          if (word_out !== w) begin
            errors++;
            $display("FAIL %s word%0d: got %h want %h", nm, acc, word_out, w);
          end
          checks++;
          if (row_idx !== 2'(acc / WORDS)) begin
            errors++;
            $display("FAIL %s row_idx: got %0d want %0d", nm, row_idx, acc / WORDS);
          end
          acc++;
          last_acc = cyc;
        end
        prev_hold = word_valid && !word_ready && !ab;
        prev_w = word_out;
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: no done/abort within bound", nm);
    end
    interrupt = 0;
    word_ready = 0;
    @(negedge clk);
    checks++;
    if (busy !== 0 || stop !== 1 || done !== 0) begin
      errors++;
      $display("FAIL %s end_idle: busy=%b stop=%b done=%b want 0 1 0",
               nm, busy, stop, done);
    end
  endtask

  task automatic test_basic;
    xfer("basic", 1, 0, -1, 0, 0, 1);
  endtask

  task automatic test_backpressure;
    xfer("bp1001", 1, 1, -1, 0, 0, 0);
    xfer("bprand", 2, 2, -1, 0, 0, 0);
  endtask

  task automatic test_multi_row;
    xfer("multi", 5, 0, -1, 0, 0, 0);
  endtask

  task automatic test_abort;
    xfer("abort", 1, 0, 1, 7, 0, 0);
    xfer("restart", 1, 0, -1, 0, 0, 0);
    xfer("abort_last", 1, 2, ROWS - 1, WORDS - 1, 0, 0);
    xfer("abort_req", 3, 0, 0, 0, 0, 0);
  endtask

  task automatic test_ignored;
    xfer("poke", 1, 2, -1, 0, 1, 0);
    @(negedge clk);
    start = 1;
    interrupt = 1;
    @(negedge clk);
    start = 0;
    interrupt = 0;
    repeat (3) begin
      checks++;
      if (busy !== 0 || row_req !== 0 || stop !== 1) begin
        errors++;
        $display("FAIL start_int: busy=%b req=%b stop=%b want 0 0 1",
                 busy, row_req, stop);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    while (!row_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    for (int i = 0; i < WORDS; i++) row_in[i*WORD_W +: WORD_W] = WORD_W'($urandom);
    row_valid = 1;
    word_ready = 1;
    @(negedge clk);
    row_valid = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (word_valid !== 1) begin
      errors++;
      $display("FAIL rst_mid_pre: word_valid=%b want 1", word_valid);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (busy !== 0 || word_valid !== 0 || word_out !== 0 ||
        stop !== 1 || row_idx !== 0 || row_req !== 0 || done !== 0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b wv=%b wo=%h stop=%b idx=%0d want 0 0 0 1 0",
               busy, word_valid, word_out, stop, row_idx);
    end
    word_ready = 0;
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 0 || word_valid !== 0) begin
      errors++;
      $display("FAIL rst_mid_after: busy=%b wv=%b want 0 0", busy, word_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_multi_row();
    test_abort();
    test_ignored();
    test_reset_mid();
    xfer("final", 1, 2, -1, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
